// File: rtl/fir_result_collector.sv
// fir_result_collector: captures FIR results, rounds/shifts/saturates them to a
// narrow signed word, buffers them in a small FIFO drained over valid/ready, and
// tracks run progress against a programmed output length.
module fir_result_collector #(
    parameter int IW    = 12,
    parameter int OW    = 2*IW+7,
    parameter int DW    = 16,
    parameter int DEPTH = 16,
    parameter int SHW   = 5
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_start,
    input  logic [15:0]              i_output_length,
    input  logic [SHW-1:0]           i_shift,
    input  logic signed [OW-1:0]     i_result,
    input  logic                     i_result_valid,
    input  logic                     i_strobe,
    output logic signed [DW-1:0]     o_data,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_overflow,
    output logic                     o_sat
);

    localparam int AW = $clog2(DEPTH);
    localparam logic signed [OW:0] P_MAX = (OW+1)'(2**(DW-1) - 1);
    localparam logic signed [OW:0] P_MIN = ~P_MAX;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN, S_DONE} state_t;

    // Round-half-up then arithmetic right shift; one guard bit keeps the bias add from wrapping.
    function automatic logic signed [OW:0] f_round_shift(input logic signed [OW-1:0] v,
                                                         input logic [SHW-1:0] sh);
        logic signed [OW:0] ext;
        logic signed [OW:0] bias;
        ext  = {v[OW-1], v};
        bias = '0;
        if (sh != '0) bias = (OW+1)'(1) << (sh - 1'b1);
        return (ext + bias) >>> sh;
    endfunction

    function automatic logic f_clipped(input logic signed [OW:0] v);
        return (v > P_MAX) || (v < P_MIN);
    endfunction

    function automatic logic signed [DW-1:0] f_saturate(input logic signed [OW:0] v);
        logic signed [DW-1:0] res;
        if (v > P_MAX)      res = P_MAX[DW-1:0];
        else if (v < P_MIN) res = P_MIN[DW-1:0];
        else                res = v[DW-1:0];
        return res;
    endfunction

    state_t                r_state;
    state_t                w_state_next;
    logic [15:0]           r_len;
    logic [SHW-1:0]        r_shift;
    logic [15:0]           r_acc_cnt;
    logic                  r_vld_p1;
    logic signed [DW-1:0]  r_data_p1;
    logic signed [DW-1:0]  r_mem [DEPTH];
    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [AW:0]           r_count;
    logic                  r_overflow;
    logic                  r_sat;

    logic                  w_accept;
    logic                  w_len_reached;
    logic [SHW-1:0]        w_shift_clamped;
    logic signed [OW:0]    w_scaled;
    logic                  w_full;
    logic                  w_rd;
    logic                  w_wr;
    logic                  w_drop;

    assign w_shift_clamped = (int'(i_shift) > OW-1) ? SHW'(OW-1) : i_shift;
    assign w_accept        = (r_state == S_COLLECT) && i_strobe && i_result_valid &&
                             (r_acc_cnt < r_len) && !i_start;
    assign w_len_reached   = ({1'b0, r_acc_cnt} + 17'(w_accept)) >= {1'b0, r_len};
    assign w_scaled        = f_round_shift(i_result, r_shift);

    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_rd    = (r_count != '0) && i_ready;
    assign w_wr    = r_vld_p1 && (!w_full || w_rd);
    assign w_drop  = r_vld_p1 && w_full && !w_rd;

    assign o_data     = (r_count != '0) ? r_mem[r_rptr] : '0;
    assign o_valid    = (r_count != '0);
    assign o_count    = r_count;
    assign o_full     = w_full;
    assign o_busy     = (r_state == S_COLLECT) || (r_state == S_DRAIN);
    assign o_done     = (r_state == S_DONE);
    assign o_overflow = r_overflow;
    assign o_sat      = r_sat;

    // Run state register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= S_IDLE;
        else            r_state <= w_state_next;
    end

    // Next-state decode; a start pulse restarts collection from any state.
    always_comb begin
        w_state_next = r_state;
        if (i_start) begin
            w_state_next = S_COLLECT;
        end else begin
            case (r_state)
                S_IDLE:    w_state_next = S_IDLE;
                S_COLLECT: if (w_len_reached) w_state_next = S_DRAIN;
                S_DRAIN:   if ((r_count == '0) && !r_vld_p1) w_state_next = S_DONE;
                S_DONE:    w_state_next = S_DONE;
                default:   w_state_next = S_IDLE;
            endcase
        end
    end

    // Latch run configuration on start; shift is clamped so it never exceeds OW-1.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_len   <= '0;
            r_shift <= '0;
        end else if (i_start) begin
            r_len   <= i_output_length;
            r_shift <= w_shift_clamped;
        end
    end

    // Stage 1: accept counter, scaled word, and sticky saturation flag.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_acc_cnt <= '0;
            r_vld_p1  <= 1'b0;
            r_data_p1 <= '0;
            r_sat     <= 1'b0;
        end else if (i_start) begin
            r_acc_cnt <= '0;
            r_vld_p1  <= 1'b0;
            r_sat     <= 1'b0;
        end else begin
            r_vld_p1 <= w_accept;
            if (w_accept) begin
                r_acc_cnt <= r_acc_cnt + 16'd1;
                r_data_p1 <= f_saturate(w_scaled);
                if (f_clipped(w_scaled)) r_sat <= 1'b1;
            end
        end
    end

    // FIFO control: pointers, occupancy and sticky overflow; start flushes everything.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (i_start) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    // FIFO storage; when full with a simultaneous read the freed head slot takes the new word.
    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wptr] <= r_data_p1;
    end

endmodule

// File: doc/fir_result_collector.md
Name: fir_result_collector

Overview:
- Downstream neighbour of the generic FIR filter in the APB accelerator.
- Captures each valid filter result and rounds and scales it by a programmable right shift, saturating to a narrow signed word.
- Buffers the scaled word in a small FIFO drained by the APB/DMA side over a valid/ready handshake.
- Counts results against the programmed output length and reports completion, overflow and saturation.

Parameters:
- IW, 12, filter input sample width (informational; sets OW default)
- OW, 2*IW+7, width of the filter result input (signed)
- DW, 16, width of the scaled output word (signed)
- DEPTH, 16, FIFO depth; must be a power of 2, at least 2
- SHW, 5, width of the shift-amount field

Ports:
- i_clk, in, 1, clock
- i_reset_n, in, 1, asynchronous active-low reset
- i_start, in, 1, single-cycle pulse: flush and arm a new run
- i_output_length, in, 16, number of results to collect; latched on i_start
- i_shift, in, SHW, arithmetic right-shift amount; latched on i_start; values above OW-1 are clamped to OW-1
- i_result, in, OW, signed filter result
- i_result_valid, in, 1, filter reports its result as meaningful (level)
- i_strobe, in, 1, a new result is present on i_result this cycle (registered copy of the filter's i_ce)
- o_data, out, DW, FIFO head word
- o_valid, out, 1, o_data is valid
- i_ready, in, 1, consumer accepts o_data
- o_count, out, $clog2(DEPTH)+1, FIFO occupancy
- o_full, out, 1, o_count == DEPTH
- o_busy, out, 1, state is COLLECT or DRAIN
- o_done, out, 1, state is DONE
- o_overflow, out, 1, sticky: a result was dropped because the FIFO was full
- o_sat, out, 1, sticky: at least one result saturated

Behaviour:
- Reset (i_reset_n low, asynchronous): state IDLE, FIFO empty. All of these are 0: o_data, o_valid, o_count, o_full, o_busy, o_done, o_overflow, o_sat. Accepted-result counter and stage-1 register are also cleared.
- FSM states: IDLE, COLLECT, DRAIN, DONE.
  - IDLE to COLLECT on i_start.
  - COLLECT to DRAIN on the edge where the accepted count reaches the latched length. A latched length of 0 goes to DRAIN on the first edge in COLLECT.
  - DRAIN to DONE when the FIFO is empty and stage 1 is empty.
  - DONE holds until i_start.
- i_start in any state, including mid-run:
  - flushes the FIFO and stage 1;
  - clears the counter, o_overflow and o_sat;
  - latches i_output_length and i_shift;
  - enters COLLECT on the next edge.
- Accept condition: state COLLECT and i_strobe and i_result_valid, with count < length. Anything outside COLLECT is ignored.
- Scaling, stage 1, registered on the accept edge:
  - If shift = 0, the value passes through unchanged.
  - Otherwise add 2^(shift-1), then arithmetic right shift by shift. Use OW+1 bits internally so the rounding add cannot wrap.
  - Saturate to [-2^(DW-1), 2^(DW-1)-1] and set o_sat if clipped.
- FIFO write happens on the edge after stage 1 loads. Latency from accept edge to o_valid is 2 edges when the FIFO was empty.
- Handshake:
  - A read occurs on an edge where o_valid and i_ready are both high.
  - o_data and o_valid are held stable while o_valid is high and i_ready is low.
  - o_data is the FIFO head; it is 0 when the FIFO is empty.
- FIFO full:
  - Write with a simultaneous read: both happen and the count is unchanged.
  - Write without a read: the word is dropped, o_overflow is set, and the result still counts toward the length.
- FIFO empty: a read request is ignored; o_count never underflows.
- Pointers wrap modulo DEPTH. o_count equals the write count minus the read count.
- Back-to-back strobes every cycle are sustained at 1 result per cycle.

Test Plan:
- Pass-through scaling:
  - Stimulus: length=4, shift=0, i_ready=1, results 5, -3, 100, 0 on consecutive strobes.
  - Required: o_data 5, -3, 100, 0, with the first o_valid 2 edges after the first accept.
  - Required: o_done after the last read; o_sat=0, o_overflow=0.
- Rounding and saturation:
  - Stimulus: shift=4, inputs 24, -24, 7, 0x3FFFFFF, -0x4000000.
  - Required outputs: 2, -1, 0, 32767, -32768.
  - Required: o_sat=1.
- Overflow:
  - Stimulus: DEPTH=16, length=20, i_ready=0.
  - Required: o_full after 16 writes; 4 results dropped; o_overflow=1; state DRAIN.
  - Then raise i_ready: exactly 16 words are read, then o_done.
- Valid gating and length 0:
  - Strobes with i_result_valid=0 produce no writes.
  - length=0 reaches DONE within 2 edges of i_start with no writes.
- Simultaneous events:
  - Stimulus: FIFO full, with a read and a write on the same edge.
  - Required: o_count stays 16; o_overflow stays 0; ordering is preserved.
- Reset and restart:
  - Asserting i_reset_n low mid-COLLECT immediately zeroes all outputs.
  - i_start mid-DRAIN flushes the FIFO and clears the sticky flags.
  - A new run of length=2 then completes with correct data.
